// File: rtl/qr_pkg.sv
// Constants and types shared by the QR engine, its input streamer and the bench.
// The sample layout is {re[47:24], im[23:0]}.
package qr_pkg;

  localparam int DATA_W    = 48;
  localparam int GROUP_LEN = 20;
  localparam int N_GROUPS  = 10;
  localparam int FRAME_LEN = GROUP_LEN * N_GROUPS;
  localparam int DEPTH     = 256;
  localparam int AW        = 8;
  localparam int BEAT_W    = 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/qr_sample_fifo.sv
// Circular sample buffer with an occupancy count 0..DEPTH.
// The head entry is visible combinationally so the caller can register it on pop.
module qr_sample_fifo
  import qr_pkg::*;
#(
  parameter int P_DATA_W = DATA_W,
  parameter int P_DEPTH  = DEPTH,
  parameter int P_AW     = AW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [P_DATA_W-1:0] i_din,
  output logic [P_DATA_W-1:0] o_dout,
  output logic [P_AW:0]     o_count
);

  localparam logic [P_AW-1:0] LAST_PTR  = P_AW'(P_DEPTH - 1);
  localparam logic [P_AW:0]   FULL_CNT  = (P_AW + 1)'(P_DEPTH);

  logic [P_DATA_W-1:0] r_mem [P_DEPTH];
  logic [P_AW-1:0]     r_wr_ptr;
  logic [P_AW-1:0]     r_rd_ptr;
  logic [P_AW:0]       r_count;
  logic                w_push;
  logic                w_pop;

  // Guard against misuse so the count can never leave 0..DEPTH.
  assign w_push = i_push && (r_count != FULL_CNT);
  assign w_pop  = i_pop  && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/qr_frame_streamer.sv
// Buffers upstream samples and replays them to the QR engine as gap-free
// FRAME_LEN-beat bursts, pacing each new burst on the engine's done pulse.
module qr_frame_streamer
  import qr_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_trig,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_last_data,
  output logic              o_busy,
  output logic [15:0]       o_frame_cnt,
  output logic              o_proto_err
);

  localparam int              CNT_W     = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  state_t              r_state;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_trig;
  logic [DATA_W-1:0]   r_data;
  logic                r_busy;
  logic [15:0]         r_frame_cnt;
  logic                r_proto_err;

  logic [CNT_W-1:0]    w_count;
  logic [DATA_W-1:0]   w_head;
  logic                w_push;
  logic                w_pop;

  assign o_in_ready = (w_count != FULL_CNT);
  assign w_push     = i_in_valid && o_in_ready;
  assign w_pop      = (r_state == SEND);

  qr_sample_fifo #(
    .P_DATA_W (DATA_W),
    .P_DEPTH  (DEPTH),
    .P_AW     (AW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_in_data),
    .o_dout  (w_head),
    .o_count (w_count)
  );

  // SEND is only entered with a full frame buffered, so every pop is backed by data.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_trig      <= 1'b0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      r_data <= '0;
      if (i_last_data && (r_state != WAIT_DONE)) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_count >= FRAME_CNT) begin
            r_state <= SEND;
            r_busy  <= 1'b1;
            r_beat  <= '0;
          end
        end
        SEND: begin
          r_trig <= 1'b1;
          r_data <= w_head;
          r_beat <= r_beat + 1'b1;
          if (r_beat == LAST_BEAT) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (i_last_data) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_trig      = r_trig;
  assign o_data      = r_data;
  assign o_busy      = r_busy;
  assign o_frame_cnt = r_frame_cnt;
  assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_qr_frame_streamer.sv
// Directed bench for qr_frame_streamer: reset, single frames, threshold,
// back-pressure, protocol error and mid-burst reset.
module tb_qr_frame_streamer;
  import qr_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              trig;
  logic [DATA_W-1:0] data;
  logic              last_data;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic              proto_err;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] cap_q [$];
  int                bursts [$];
  int                run_len = 0;

  qr_frame_streamer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_trig      (trig),
    .o_data      (data),
    .i_last_data (last_data),
    .o_busy      (busy),
    .o_frame_cnt (frame_cnt),
    .o_proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every burst beat and burst length just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (trig === 1'b1) begin
      cap_q.push_back(data);
      run_len++;
    end else if (run_len > 0) begin
      bursts.push_back(run_len);
      run_len = 0;
    end
  end

  function automatic logic [DATA_W-1:0] sample(input int k);
    logic [23:0] kk;
    kk = 24'(k);
    return {kk, kk ^ 24'hA5A5A5};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    last_data = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cap_q.delete();
    bursts.delete();
  endtask

  task automatic push_n(input int first, input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = sample(first + i);
      guard    = 0;
      while (!in_ready && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        chk("push_timeout", 64'(in_ready), 64'd1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic pulse_last();
    last_data = 1'b1;
    @(negedge clk);
    last_data = 1'b0;
  endtask

  task automatic wait_bursts(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (bursts.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(bursts.size() >= n), 64'd1);
  endtask

  task automatic wait_trig(input string tag, input int budget);
    int k;
    k = 0;
    while (trig !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(trig), 64'd1);
  endtask

  task automatic check_frame(input string tag, input int base, input int first);
    int bad_before;
    logic [DATA_W-1:0] got;
    bad_before = bad;
    for (int i = 0; i < FRAME_LEN; i++) begin
      got = (base + i < cap_q.size()) ? cap_q[base + i] : 'x;
      chk(tag, 64'(got), 64'(sample(first + i)));
      if (bad != bad_before) break;
    end
  endtask

  initial begin
    // 1: reset values
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    last_data = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", 64'(trig), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd1);
    $display("txn reset: trig=%0b busy=%0b ready=%0b", trig, busy, in_ready);

    // 2: one frame, done pulse 50 cycles after the burst
    cap_q.delete();
    bursts.delete();
    push_n(0, FRAME_LEN);
    wait_bursts("t2_burst_wait", 1, 400);
    chk("t2_burst_len", 64'(bursts[0]), 64'(FRAME_LEN));
    check_frame("t2_data", 0, 0);
    chk("t2_data_idle", 64'(data), 64'd0);
    repeat (50) @(negedge clk);
    chk("t2_busy_wait", 64'(busy), 64'd1);
    chk("t2_cnt_before", 64'(frame_cnt), 64'd0);
    pulse_last();
    chk("t2_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t2_busy_after", 64'(busy), 64'd0);
    chk("t2_proto_err", 64'(proto_err), 64'd0);
    $display("txn frame: len=%0d frame_cnt=%0d", bursts[0], frame_cnt);

    // 3: threshold at exactly FRAME_LEN buffered samples
    cap_q.delete();
    bursts.delete();
    push_n(1000, FRAME_LEN - 1);
    repeat (100) @(negedge clk);
    chk("t3_no_burst", 64'(bursts.size()), 64'd0);
    chk("t3_trig_low", 64'(trig), 64'd0);
    chk("t3_busy_low", 64'(busy), 64'd0);
    push_n(1000 + FRAME_LEN - 1, 1);
    chk("t3_trig_p0", 64'(trig), 64'd0);
    @(negedge clk);
    chk("t3_trig_p1", 64'(trig), 64'd0);
    @(negedge clk);
    chk("t3_trig_p2", 64'(trig), 64'd1);
    wait_bursts("t3_burst_wait", 1, 400);
    chk("t3_burst_len", 64'(bursts[0]), 64'(FRAME_LEN));
    check_frame("t3_data", 0, 1000);
    pulse_last();
    chk("t3_frame_cnt", 64'(frame_cnt), 64'd2);
    $display("txn threshold: len=%0d frame_cnt=%0d", bursts[0], frame_cnt);

    // 4: 456 samples with no done pulse fills the buffer
    do_reset();
    push_n(0, 456);
    chk("t4_ready_full", 64'(in_ready), 64'd0);
    chk("t4_busy", 64'(busy), 64'd1);
    chk("t4_burst1_cnt", 64'(bursts.size()), 64'd1);
    chk("t4_burst1_len", 64'(bursts[0]), 64'(FRAME_LEN));
    check_frame("t4_data1", 0, 0);
    pulse_last();
    chk("t4_frame_cnt", 64'(frame_cnt), 64'd1);
    wait_bursts("t4_burst2_wait", 2, 400);
    chk("t4_burst2_len", 64'(bursts[1]), 64'(FRAME_LEN));
    check_frame("t4_data2", FRAME_LEN, FRAME_LEN);
    chk("t4_ready_after", 64'(in_ready), 64'd1);
    $display("txn backpressure: bursts=%0d frame_cnt=%0d", bursts.size(), frame_cnt);

    // 5: done pulse during SEND is a protocol error and is otherwise ignored
    do_reset();
    push_n(2000, FRAME_LEN);
    wait_trig("t5_trig_wait", 50);
    repeat (20) @(negedge clk);
    pulse_last();
    chk("t5_proto_set", 64'(proto_err), 64'd1);
    chk("t5_busy_send", 64'(busy), 64'd1);
    wait_bursts("t5_burst_wait", 1, 400);
    chk("t5_burst_len", 64'(bursts[0]), 64'(FRAME_LEN));
    chk("t5_cnt_before", 64'(frame_cnt), 64'd0);
    pulse_last();
    chk("t5_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t5_proto_sticky", 64'(proto_err), 64'd1);
    $display("txn proto_err: err=%0b frame_cnt=%0d", proto_err, frame_cnt);

    // 6: reset at beat 73 of a burst, then a clean frame
    do_reset();
    push_n(3000, FRAME_LEN);
    wait_trig("t6_trig_wait", 50);
    repeat (73) @(negedge clk);
    chk("t6_beat73", 64'(data), 64'(sample(3000 + 73)));
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_trig_rst", 64'(trig), 64'd0);
    chk("t6_data_rst", 64'(data), 64'd0);
    chk("t6_busy_rst", 64'(busy), 64'd0);
    chk("t6_ready_rst", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cap_q.delete();
    bursts.delete();
    push_n(4000, FRAME_LEN);
    wait_bursts("t6_burst_wait", 1, 400);
    chk("t6_burst_len", 64'(bursts[0]), 64'(FRAME_LEN));
    check_frame("t6_data", 0, 4000);
    $display("txn mid_reset: len=%0d", bursts[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
